// File: rtl/refresh_sched_pkg.sv
// Shared definitions for the refresh scheduler.
// Holds the scheduler state encoding and the default parameter values
// used by refresh_sched and refresh_timer.
package refresh_sched_pkg;

    localparam int RATE_W_DEF = 12;  // interval register / down-counter width
    localparam int PEND_W_DEF = 3;   // owed-refresh counter width
    localparam int URG_TH_DEF = 4;   // backlog level that flags urgency

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        BUSY = 2'b10
    } state_t;

endpackage

// File: rtl/refresh_sched_if.sv
// Refresh handshake between the scheduler, the bus arbiter and the
// memory controller.
//   refreq  : refresh request to the arbiter (scheduler drives)
//   refurg  : backlog is at or above the urgency threshold (scheduler drives)
//   refack  : arbiter grant level for the refresh slot (scheduler samples)
//   refdone : one-cycle completion pulse from the memory controller
// master = scheduler side, slave = arbiter / memory-controller side.
interface refresh_sched_if;

    logic refreq;
    logic refurg;
    logic refack;
    logic refdone;

    modport master (output refreq, output refurg, input refack, input refdone);
    modport slave  (input refreq, input refurg, output refack, output refdone);

endinterface

// File: rtl/refresh_timer.sv
// Programmable refresh interval timer.
// Ports:
//   clk, resetl : clock, synchronous active-low reset
//   rate_ld     : write strobe for the interval register
//   rate_din    : new interval, in clocks (0 stops the timer)
//   tick        : high for the cycle that ends one full interval
module refresh_timer
    import refresh_sched_pkg::*;
#(
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              rate_ld,
    input  logic [RATE_W-1:0] rate_din,
    output logic              tick
);

    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] cnt;

    // cnt holds "clocks left minus one", so cnt==0 marks the last clock of
    // an interval. Loading D gives the first tick D clocks after the write.
    // A write restarts the interval, so any tick in that cycle is dropped.
    assign tick = !rate_ld && (rate != '0) && (cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            rate <= '0;
            cnt  <= '0;
        end else if (rate_ld) begin
            rate <= rate_din;
            cnt  <= rate_din - RATE_W'(1);
        end else if (rate != '0) begin
            cnt <= (cnt == '0) ? rate - RATE_W'(1) : cnt - RATE_W'(1);
        end
    end

endmodule

// File: rtl/refresh_sched.sv
// DRAM refresh scheduler.
// Divides clk by a programmable interval, keeps a saturating count of owed
// refreshes and runs the request/grant/done handshake for each refresh.
// Ports:
//   clk, resetl : clock, synchronous active-low reset
//   rate_ld     : interval register write strobe
//   rate_din    : new interval in clocks (0 stops ticking)
//   refen       : when low, timer ticks are not counted
//   bus         : refreq/refurg out, refack/refdone in (master side)
//   pend        : current owed-refresh count
//   refovf      : sticky, a tick was lost while pend was saturated
module refresh_sched
    import refresh_sched_pkg::*;
#(
    parameter int RATE_W = RATE_W_DEF,
    parameter int PEND_W = PEND_W_DEF,
    parameter int URG_TH = URG_TH_DEF
) (
    input  logic                clk,
    input  logic                resetl,
    input  logic                rate_ld,
    input  logic [RATE_W-1:0]   rate_din,
    input  logic                refen,
    refresh_sched_if.master     bus,
    output logic [PEND_W-1:0]   pend,
    output logic                refovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] URG_LVL  = PEND_W'(URG_TH);

    logic              tick;
    logic              tick_cnt;
    logic              done_acc;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;
    state_t            state;
    state_t            state_nxt;
    logic              refreq_q;
    logic              refurg_q;

    refresh_timer #(.RATE_W(RATE_W)) u_timer (
        .clk      (clk),
        .resetl   (resetl),
        .rate_ld  (rate_ld),
        .rate_din (rate_din),
        .tick     (tick)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        tick_cnt  = tick && refen;
        done_acc  = bus.refdone && (state == BUSY);
        pend_nxt  = pend;
        ovf_nxt   = refovf;
        state_nxt = state;

        // A counted tick and an accepted done in the same cycle cancel.
        if (tick_cnt && !done_acc) begin
            if (pend == PEND_MAX) ovf_nxt = 1'b1;
            else                  pend_nxt = pend + PEND_W'(1);
        end else if (done_acc && !tick_cnt) begin
            pend_nxt = pend - PEND_W'(1);
        end

        unique case (state)
            // Uses the registered backlog, so the request follows the
            // tick that raised pend by one cycle.
            IDLE: if (pend != '0) state_nxt = REQ;
            REQ:  if (bus.refack) state_nxt = BUSY;
            BUSY: if (done_acc)   state_nxt = (pend_nxt != '0) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            state    <= IDLE;
            pend     <= '0;
            refovf   <= 1'b0;
            refreq_q <= 1'b0;
            refurg_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            refovf   <= ovf_nxt;
            refreq_q <= (state_nxt == REQ);
            refurg_q <= (pend_nxt >= URG_LVL);
        end
    end

    assign bus.refreq = refreq_q;
    assign bus.refurg = refurg_q;

endmodule

// File: tb/tb_refresh_sched.sv
// Self-checking bench for refresh_sched: directed phases plus a random
// phase, all checked every cycle against a behavioural model.
module tb_refresh_sched;

    logic        clk = 1'b0;
    logic        resetl;
    logic        rate_ld;
    logic [11:0] rate_din;
    logic        refen;
    logic [2:0]  pend;
    logic        refovf;

    refresh_sched_if bus ();

    refresh_sched dut (
        .clk      (clk),
        .resetl   (resetl),
        .rate_ld  (rate_ld),
        .rate_din (rate_din),
        .refen    (refen),
        .bus      (bus.master),
        .pend     (pend),
        .refovf   (refovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ticks from edge arithmetic, backlog as an integer.
    int edge_n = 0;
    int m_rate = 0;
    int m_load = 0;
    int m_pend = 0;
    bit m_ovf  = 0;
    bit m_req  = 0;
    bit m_busy = 0;
    bit m_urg  = 0;
    int busy_age = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic model_update();
        bit tick, counted, done_ok;
        int old;
        if (!resetl) begin
            m_rate = 0; m_load = edge_n; m_pend = 0;
            m_ovf = 0; m_req = 0; m_busy = 0; m_urg = 0;
            return;
        end
        tick = 0;
        if (rate_ld) begin
            m_rate = int'(rate_din);
            m_load = edge_n;
        end else if (m_rate != 0 && ((edge_n - m_load) % m_rate) == 0) begin
            tick = 1;
        end
        counted = tick && refen;
        done_ok = bus.refdone && m_busy;
        old = m_pend;
        if (counted && !done_ok) begin
            if (m_pend == 7) m_ovf = 1;
            else m_pend++;
        end else if (done_ok && !counted) begin
            m_pend--;
        end
        if (m_busy) begin
            if (done_ok) begin
                m_busy = 0;
                m_req  = (m_pend > 0);
            end
        end else if (m_req) begin
            if (bus.refack) begin
                m_req  = 0;
                m_busy = 1;
            end
        end else if (old > 0) begin
            m_req = 1;
        end
        m_urg = (m_pend >= 4);
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        edge_n++;
        model_update();
        #1;
        busy_age = m_busy ? busy_age + 1 : 0;
        check("refreq", 32'(bus.refreq), 32'(m_req));
        check("refurg", 32'(bus.refurg), 32'(m_urg));
        check("pend",   32'(pend),       32'(m_pend));
        check("refovf", 32'(refovf),     32'(m_ovf));
    endtask

    task automatic drive(input bit ld, input int din, input bit ack, input bit done);
        rate_ld     = ld;
        rate_din    = 12'(din);
        bus.refack  = ack;
        bus.refdone = done;
    endtask

    // Grant one cycle after request; complete every grant as soon as busy.
    task automatic drain(input int budget);
        int n = 0;
        while ((m_pend != 0 || m_busy || m_req) && n < budget) begin
            drive(0, 0, 1'b1, m_busy);
            step();
            n++;
        end
        check("drain_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int rises;
        bit prev_req;

        resetl = 1'b0; refen = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) step();
        resetl = 1'b1;

        // Periodic service at rate 10: ack follows req, done 3 clocks after grant.
        refen = 1'b1;
        drive(1, 10, 0, 0);
        step();
        rises = 0; prev_req = 0;
        for (int i = 0; i < 65; i++) begin
            drive(0, 0, bus.refreq, busy_age == 3);
            step();
            if (bus.refreq && !prev_req) rises++;
            prev_req = bus.refreq;
        end
        check("req_pulses", 32'(rises), 32'd6);
        check("pend_zero", 32'(pend), 32'd0);
        check("ovf_clear", 32'(refovf), 32'd0);

        // Rate 4, no grant for 40 clocks: backlog saturates.
        drive(1, 4, 0, 0);
        step();
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 0);
            step();
        end
        check("pend_sat", 32'(pend), 32'd7);
        check("ovf_set", 32'(refovf), 32'd1);
        check("urg_set", 32'(bus.refurg), 32'd1);

        // Stop the timer and drain with back-to-back grants.
        drive(1, 0, 1, 0);
        step();
        drain(40);
        check("drained", 32'(pend), 32'd0);
        check("ovf_sticky", 32'(refovf), 32'd1);

        // refdone in IDLE is ignored.
        drive(0, 0, 0, 1);
        step();
        check("idle_done_pend", 32'(pend), 32'd0);

        // Tick coincident with accepted done at pend=2.
        drive(1, 3, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0);
            step();
        end
        check("pend_two", 32'(pend), 32'd2);
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0); step();
        drive(0, 0, 0, 1); step();
        check("coinc_pend", 32'(pend), 32'd2);
        check("coinc_req", 32'(bus.refreq), 32'd1);

        // refdone in REQ is ignored.
        drive(0, 0, 0, 1); step();
        check("req_done_pend", 32'(pend), 32'd2);
        check("req_done_req", 32'(bus.refreq), 32'd1);
        drive(1, 0, 0, 0); step();
        drain(40);

        // Reset while busy with pend=3.
        drive(1, 2, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0);
            step();
        end
        drive(0, 0, 1, 0); step();
        check("busy_pend3", 32'(pend), 32'd3);
        drive(0, 0, 0, 0);
        resetl = 1'b0; step();
        resetl = 1'b1;
        check("rst_req", 32'(bus.refreq), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("no_ticks_after_rst", 32'(pend), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            refen = ($urandom % 8) != 0;
            drive(($urandom % 40) == 0, $urandom_range(0, 6),
                  $urandom % 2 == 1, ($urandom % 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
